// File: rtl/rom_dn_router.sv
// Routes an ioctl ROM image download into region-local write strobes and
// sequences the game core reset around the load.
module rom_dn_router #(
  parameter logic [16:0] CPU_END     = 17'h0C000,
  parameter logic [16:0] GFX_END     = 17'h14000,
  parameter logic [16:0] SND_END     = 17'h16000,
  parameter logic [16:0] TOTAL_SIZE  = 17'h16200,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  region_sel,
  output logic        core_reset,
  output logic        load_done,
  output logic        overflow_err,
  output logic        short_err
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [17:0] TotalCnt = {1'b0, TOTAL_SIZE};

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

  state_e           state_q, state_d;
  logic [17:0]      byte_cnt_q, byte_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             ovf_q, ovf_d;
  logic             short_q, short_d;
  logic             dn_wr_q;
  logic [16:0]      dn_addr_q;
  logic [7:0]       dn_data_q;
  logic [3:0]       sel_q;

  logic             load_entry;
  logic             write_window;
  logic             accept;
  logic             drop;
  logic             in_range;
  logic [16:0]      addr_lo;
  logic [16:0]      base;
  logic [3:0]       sel;

  // Any set bit above [16] puts the address beyond the image.
  assign addr_lo  = ioctl_addr[16:0];
  assign in_range = (ioctl_addr[24:17] == 8'd0) && (addr_lo < TOTAL_SIZE);

  always_comb begin
    sel  = 4'b1000;
    base = SND_END;
    if (addr_lo < CPU_END) begin
      sel  = 4'b0001;
      base = 17'd0;
    end else if (addr_lo < GFX_END) begin
      sel  = 4'b0010;
      base = CPU_END;
    end else if (addr_lo < SND_END) begin
      sel  = 4'b0100;
      base = GFX_END;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_entry = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ioctl_download) begin
          state_d    = StLoad;
          load_entry = 1'b1;
        end
      end
      StLoad: begin
        if (!ioctl_download) begin
          state_d = (byte_cnt_q >= TotalCnt) ? StHold : StIdle;
        end
      end
      StHold: begin
        if (ioctl_download) begin
          state_d    = StLoad;
          load_entry = 1'b1;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (ioctl_download) begin
          state_d    = StLoad;
          load_entry = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The cycle that enters LOAD already accepts writes.
  assign write_window = ioctl_wr && ioctl_download && ((state_q == StLoad) || load_entry);
  assign accept       = write_window && in_range;
  assign drop         = write_window && !in_range;

  always_comb begin
    byte_cnt_d = load_entry ? 18'd0 : byte_cnt_q;
    if (accept && (byte_cnt_d != '1)) begin
      byte_cnt_d = byte_cnt_d + 18'd1;
    end
    hold_cnt_d = '0;
    if ((state_q == StHold) && (state_d == StHold)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    ovf_d   = (load_entry ? 1'b0 : ovf_q) | drop;
    short_d = (load_entry ? 1'b0 : short_q) | ((state_q == StLoad) && (state_d == StIdle));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
      dn_wr_q    <= 1'b0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
      dn_wr_q    <= accept;
      if (accept) begin
        dn_addr_q <= addr_lo - base;
        dn_data_q <= ioctl_dout;
        sel_q     <= sel;
      end
    end
  end

  assign dn_wr        = dn_wr_q;
  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign region_sel   = sel_q;
  assign core_reset   = (state_q != StRun);
  assign load_done    = (state_q == StRun);
  assign overflow_err = ovf_q;
  assign short_err    = short_q;

endmodule

// File: tb/tb_rom_dn_router.sv
// Bench for rom_dn_router: decode table on a default-sized instance, load
// sequences and randomized traffic on a shrunken instance.
module tb_rom_dn_router;

  localparam logic [16:0] CPU_E = 17'h00100;
  localparam logic [16:0] GFX_E = 17'h00180;
  localparam logic [16:0] SND_E = 17'h001C0;
  localparam logic [16:0] TOT   = 17'h001D0;
  localparam int unsigned HOLD  = 40;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  region_sel;
  logic        core_reset, load_done, overflow_err, short_err;

  logic        d_download, d_wr;
  logic [24:0] d_addr;
  logic [7:0]  d_dout;
  logic [16:0] d_dn_addr;
  logic [7:0]  d_dn_data;
  logic        d_dn_wr;
  logic [3:0]  d_region_sel;
  logic        d_core_reset, d_load_done, d_overflow_err, d_short_err;

  always #5 clk_sys = ~clk_sys;

  rom_dn_router #(
    .CPU_END(CPU_E), .GFX_END(GFX_E), .SND_END(SND_E), .TOTAL_SIZE(TOT), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wr(dn_wr), .region_sel(region_sel), .core_reset(core_reset), .load_done(load_done),
    .overflow_err(overflow_err), .short_err(short_err)
  );

  rom_dn_router dut_dflt (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(d_download), .ioctl_wr(d_wr),
    .ioctl_addr(d_addr), .ioctl_dout(d_dout), .dn_addr(d_dn_addr), .dn_data(d_dn_data),
    .dn_wr(d_dn_wr), .region_sel(d_region_sel), .core_reset(d_core_reset),
    .load_done(d_load_done), .overflow_err(d_overflow_err), .short_err(d_short_err)
  );

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic [3:0]  sel;
    logic [16:0] la;
    logic [7:0]  dat;
  } vec_t;

  vec_t        tbl [14];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [3:0]  m_sel;
  logic [16:0] m_addr;
  logic [7:0]  m_data;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference region decode from the region end addresses.
  function automatic void ref_decode(input logic [24:0] a, output bit ok, output logic [3:0] s,
                                     output logic [16:0] la);
    int unsigned ends [4];
    int unsigned base;
    bit found;
    ends[0] = 32'(CPU_E);
    ends[1] = 32'(GFX_E);
    ends[2] = 32'(SND_E);
    ends[3] = 32'(TOT);
    ok = 1'b0;
    s = 4'b0;
    la = 17'd0;
    base = 0;
    found = 1'b0;
    if (32'(a) >= 32'(TOT)) return;
    ok = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (!found && (32'(a) < ends[r])) begin
        found = 1'b1;
        s[r] = 1'b1;
        la = 17'(32'(a) - base);
      end
      if (!found) base = ends[r];
    end
  endfunction

  task automatic cyc_chk(input bit w, input logic [24:0] a, input logic [7:0] d);
    bit          ok;
    logic [3:0]  s;
    logic [16:0] la;
    ioctl_wr   = w;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    ref_decode(a, ok, s, la);
    if (w && ok) begin
      m_sel  = s;
      m_addr = la;
      m_data = d;
    end
    chk($sformatf("dn_wr @%0h", a), 32'(dn_wr), 32'(w && ok));
    chk($sformatf("region_sel @%0h", a), 32'(region_sel), 32'(m_sel));
    chk($sformatf("dn_addr @%0h", a), 32'(dn_addr), 32'(m_addr));
    chk($sformatf("dn_data @%0h", a), 32'(dn_data), 32'(m_data));
    if (w && !ok) chk($sformatf("overflow_err @%0h", a), 32'(overflow_err), 32'd1);
  endtask

  task automatic full_load(input bit with_ovf);
    ioctl_download = 1'b1;
    for (int a = 0; a < int'(TOT); a++) begin
      cyc_chk(1'b1, 25'(a), 8'(a) ^ 8'h5A);
      if (with_ovf && (a == 'h80)) cyc_chk(1'b1, 25'h0016200, 8'hEE);
    end
  endtask

  task automatic end_load();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    tick();
    chk("end dn_wr", 32'(dn_wr), 32'd0);
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (core_reset && (n < int'(HOLD) + 10)) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(HOLD));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    m_sel  = '0;
    m_addr = '0;
    m_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit          w, ok;
    logic [24:0] a;
    logic [3:0]  s;
    logic [16:0] la;
    int unsigned m_cnt, n_run;
    logic        m_ovf;

    tbl[0]  = '{25'h0000000, 8'h11, 1'b1, 4'b0001, 17'h00000, 8'h11};
    tbl[1]  = '{25'h000BFFF, 8'h22, 1'b1, 4'b0001, 17'h0BFFF, 8'h22};
    tbl[2]  = '{25'h000C000, 8'h33, 1'b1, 4'b0010, 17'h00000, 8'h33};
    tbl[3]  = '{25'h0013FFF, 8'h44, 1'b1, 4'b0010, 17'h07FFF, 8'h44};
    tbl[4]  = '{25'h0014000, 8'h55, 1'b1, 4'b0100, 17'h00000, 8'h55};
    tbl[5]  = '{25'h0015FFF, 8'h66, 1'b1, 4'b0100, 17'h01FFF, 8'h66};
    tbl[6]  = '{25'h0016000, 8'h77, 1'b1, 4'b1000, 17'h00000, 8'h77};
    tbl[7]  = '{25'h00161FF, 8'h88, 1'b1, 4'b1000, 17'h001FF, 8'h88};
    tbl[8]  = '{25'h0016200, 8'h99, 1'b0, 4'b1000, 17'h001FF, 8'h88};
    tbl[9]  = '{25'h1000000, 8'hAA, 1'b0, 4'b1000, 17'h001FF, 8'h88};
    tbl[10] = '{25'h0020000, 8'hBB, 1'b0, 4'b1000, 17'h001FF, 8'h88};
    tbl[11] = '{25'h001FFFF, 8'hCC, 1'b0, 4'b1000, 17'h001FF, 8'h88};
    tbl[12] = '{25'h060000A, 8'hDD, 1'b0, 4'b1000, 17'h001FF, 8'h88};
    tbl[13] = '{25'h0000005, 8'hEE, 1'b1, 4'b0001, 17'h00005, 8'hEE};

    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    d_download = 1'b0; d_wr = 1'b0; d_addr = '0; d_dout = '0;
    do_reset();

    chk("rst core_reset", 32'(core_reset), 32'd1);
    chk("rst dn_wr", 32'(dn_wr), 32'd0);
    chk("rst dn_addr", 32'(dn_addr), 32'd0);
    chk("rst dn_data", 32'(dn_data), 32'd0);
    chk("rst region_sel", 32'(region_sel), 32'd0);
    chk("rst load_done", 32'(load_done), 32'd0);
    chk("rst overflow_err", 32'(overflow_err), 32'd0);
    chk("rst short_err", 32'(short_err), 32'd0);
    chk("rst dflt core_reset", 32'(d_core_reset), 32'd1);

    // Default-sized decode table
    d_download = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      d_wr = 1'b1; d_addr = tbl[i].addr; d_dout = tbl[i].data;
      tick();
      d_wr = 1'b0;
      chk($sformatf("dflt[%0d] dn_wr", i), 32'(d_dn_wr), 32'(tbl[i].wr));
      chk($sformatf("dflt[%0d] region_sel", i), 32'(d_region_sel), 32'(tbl[i].sel));
      chk($sformatf("dflt[%0d] dn_addr", i), 32'(d_dn_addr), 32'(tbl[i].la));
      chk($sformatf("dflt[%0d] dn_data", i), 32'(d_dn_data), 32'(tbl[i].dat));
    end
    chk("dflt overflow_err", 32'(d_overflow_err), 32'd1);
    d_download = 1'b0;
    tick();
    chk("dflt short_err", 32'(d_short_err), 32'd1);
    chk("dflt core_reset", 32'(d_core_reset), 32'd1);
    chk("dflt load_done", 32'(d_load_done), 32'd0);

    // One byte short, with dropped writes that must not count
    ioctl_download = 1'b1;
    for (int i = 0; i < int'(TOT) - 1; i++) begin
      cyc_chk(1'b1, 25'(i), 8'(i));
      if (i == 10) cyc_chk(1'b1, 25'h0016200, 8'h01);
      if (i == 20) cyc_chk(1'b1, 25'h1000000, 8'h02);
    end
    end_load();
    chk("short1 short_err", 32'(short_err), 32'd1);
    chk("short1 overflow_err", 32'(overflow_err), 32'd1);
    repeat (HOLD + 5) tick();
    chk("short1 core_reset", 32'(core_reset), 32'd1);
    chk("short1 load_done", 32'(load_done), 32'd0);

    // 0x100-byte download; entry clears both flags
    ioctl_download = 1'b1;
    tick();
    chk("entry short_err clr", 32'(short_err), 32'd0);
    chk("entry overflow_err clr", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 'h100; i++) cyc_chk(1'b1, 25'(i), 8'(i) + 8'h3);
    end_load();
    chk("short2 short_err", 32'(short_err), 32'd1);
    repeat (HOLD + 5) tick();
    chk("short2 core_reset", 32'(core_reset), 32'd1);
    chk("short2 load_done", 32'(load_done), 32'd0);

    // Full load with one dropped write, then HOLD timing
    full_load(1'b1);
    end_load();
    chk("full hold core_reset", 32'(core_reset), 32'd1);
    wait_run("full hold cycles");
    chk("full load_done", 32'(load_done), 32'd1);
    chk("full overflow_err sticky", 32'(overflow_err), 32'd1);
    chk("full short_err", 32'(short_err), 32'd0);

    // Writes without download in RUN are ignored
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i * 7); ioctl_dout = 8'hA5;
      tick();
      ioctl_wr = 1'b0;
      chk("run nodl dn_wr", 32'(dn_wr), 32'd0);
      chk("run nodl core_reset", 32'(core_reset), 32'd0);
      chk("run nodl short_err", 32'(short_err), 32'd0);
      chk("run nodl overflow_err", 32'(overflow_err), 32'd1);
    end

    // Reload from RUN
    ioctl_download = 1'b1;
    tick();
    chk("reload core_reset", 32'(core_reset), 32'd1);
    chk("reload load_done", 32'(load_done), 32'd0);
    chk("reload overflow_err", 32'(overflow_err), 32'd0);
    chk("reload short_err", 32'(short_err), 32'd0);
    full_load(1'b0);
    end_load();
    wait_run("reload hold cycles");
    chk("reload load_done", 32'(load_done), 32'd1);

    // Reset mid-LOAD with a write in the same cycle
    ioctl_download = 1'b1;
    tick();
    cyc_chk(1'b1, 25'h3, 8'h42);
    ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'h43; reset = 1'b1;
    tick();
    reset = 1'b0; ioctl_wr = 1'b0;
    m_sel = '0; m_addr = '0; m_data = '0;
    chk("rst-load dn_wr", 32'(dn_wr), 32'd0);
    chk("rst-load dn_addr", 32'(dn_addr), 32'd0);
    chk("rst-load core_reset", 32'(core_reset), 32'd1);
    cyc_chk(1'b1, 25'h7, 8'h44);

    // Reset during HOLD
    full_load(1'b0);
    end_load();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst-hold core_reset", 32'(core_reset), 32'd1);
    chk("rst-hold dn_addr", 32'(dn_addr), 32'd0);
    chk("rst-hold short_err", 32'(short_err), 32'd0);
    n_run = 0;
    for (int i = 0; i < int'(HOLD) + 20; i++) begin
      tick();
      if (load_done || !core_reset) n_run++;
    end
    chk("rst-hold never runs", 32'(n_run), 32'd0);
    m_sel = '0; m_addr = '0; m_data = '0;

    // Randomized download against the reference model
    m_cnt = 0;
    m_ovf = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0: a = 25'($urandom_range(32'(TOT), 32'h1FFFF));
        1: a = {8'($urandom_range(1, 255)), 17'($urandom_range(0, 32'(TOT) - 1))};
        default: a = 25'($urandom_range(0, 32'(TOT) - 1));
      endcase
      cyc_chk(w, a, 8'($urandom));
      ref_decode(a, ok, s, la);
      if (w && ok) m_cnt++;
      if (w && !ok) m_ovf = 1'b1;
      chk("rand overflow_err", 32'(overflow_err), 32'(m_ovf));
    end
    end_load();
    chk("rand short_err", 32'(short_err), 32'(m_cnt < 32'(TOT)));
    repeat (HOLD + 2) tick();
    chk("rand load_done", 32'(load_done), 32'(m_cnt >= 32'(TOT)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
